// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding, port IDs.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   // Ownership state that corresponds to a port ID.
   function automatic state_t own_state(input logic port);
      return port ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/arb2_pick.sv
// Two-way tie-break for mem_arb. Build option MEM_ARB_RR_EN selects
// round-robin (last-grant register, port 0 wins the first tie after reset);
// otherwise port 0 always wins and no state is kept.
module arb2_pick
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_upd,
   input  logic i_upd_port,
   output logic o_pick
);

`ifdef MEM_ARB_RR_EN
   logic r_last;

   // Remember which port received the most recent grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last <= PORT_HOST;
      end else if (i_upd) begin
         r_last <= i_upd_port;
      end
   end

   assign o_pick = ~r_last;
`else
   logic w_unused;

   assign w_unused = ^{clk, rst, i_upd, i_upd_port};
   assign o_pick   = PORT_CORE;
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-port (core / host loader) arbiter in front of a single-port
// synchronous-read memory, with lock-based ownership and a burst cap.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-break.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned AW        = 12,
   parameter int unsigned MAX_BURST = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_0,
   input  logic             lock_0,
   input  logic             we_0,
   input  logic [AW-1:0]    addr_0,
   input  logic [WIDTH-1:0] wdata_0,
   output logic             gnt_0,
   output logic             rvalid_0,
   output logic [WIDTH-1:0] rdata_0,
   input  logic             req_1,
   input  logic             lock_1,
   input  logic             we_1,
   input  logic [AW-1:0]    addr_1,
   input  logic [WIDTH-1:0] wdata_1,
   output logic             gnt_1,
   output logic             rvalid_1,
   output logic [WIDTH-1:0] rdata_1,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_in,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_out
);

   localparam int unsigned   CW        = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_CAP = CW'(MAX_BURST);

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;
   logic [1:0]       w_req;
   logic [1:0]       w_lock;
   logic [1:0]       w_gnt;
   logic             w_own;
   logic             w_other;
   logic             w_free;
   logic             w_win;
   logic             w_pick;
   logic             w_any;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_wdata;
   logic [AW-1:0]    r_mem_addr;
   logic [WIDTH-1:0] r_mem_in;
   logic             r_rvalid_0;
   logic             r_rvalid_1;
   logic [WIDTH-1:0] r_rdata_0;
   logic [WIDTH-1:0] r_rdata_1;

   assign w_req   = {req_1, req_0};
   assign w_lock  = {lock_1, lock_0};
   assign w_own   = (r_state == OWN1);
   assign w_other = ~w_own;
   // Arbitrate with IDLE rules when nobody owns, or the owner just dropped lock.
   assign w_free  = (r_state == IDLE) || !w_lock[w_own];
   assign w_win   = (&w_req) ? w_pick : req_1;

   arb2_pick u_pick (
      .clk        (clk),
      .rst        (rst),
      .i_upd      (w_any),
      .i_upd_port (gnt_1),
      .o_pick     (w_pick)
   );

   // Grant decision, next ownership state and burst count.
   always_comb begin
      w_gnt      = 2'b00;
      w_next     = r_state;
      w_cnt_next = r_cnt;
      if (w_free) begin
         w_next     = IDLE;
         w_cnt_next = '0;
         if (|w_req) begin
            w_gnt[w_win] = 1'b1;
            if (w_lock[w_win]) begin
               w_next     = own_state(w_win);
               w_cnt_next = CW'(1);
            end
         end
      end else if ((r_cnt >= BURST_CAP) && w_req[w_other]) begin
         // Burst cap reached while the other port waits: hand over now.
         w_gnt[w_other] = 1'b1;
         if (w_lock[w_other]) begin
            w_next     = own_state(w_other);
            w_cnt_next = CW'(1);
         end else begin
            w_next     = IDLE;
            w_cnt_next = '0;
         end
      end else if (w_req[w_own]) begin
         w_gnt[w_own] = 1'b1;
         if (r_cnt < BURST_CAP) begin
            w_cnt_next = r_cnt + CW'(1);
         end
      end
   end

   // Ownership state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign gnt_0   = rst & w_gnt[0];
   assign gnt_1   = rst & w_gnt[1];
   assign w_any   = gnt_0 | gnt_1;
   assign w_addr  = gnt_1 ? addr_1  : addr_0;
   assign w_wdata = gnt_1 ? wdata_1 : wdata_0;

   assign mem_addr = w_any ? w_addr  : r_mem_addr;
   assign mem_in   = w_any ? w_wdata : r_mem_in;
   assign mem_we   = (gnt_0 & we_0) | (gnt_1 & we_1);

   // Hold the last presented address/data while no port is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_addr <= '0;
         r_mem_in   <= '0;
      end else if (w_any) begin
         r_mem_addr <= w_addr;
         r_mem_in   <= w_wdata;
      end
   end

   // Read return tracking and per-port read data hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rvalid_0 <= 1'b0;
         r_rvalid_1 <= 1'b0;
         r_rdata_0  <= '0;
         r_rdata_1  <= '0;
      end else begin
         r_rvalid_0 <= gnt_0 & ~we_0;
         r_rvalid_1 <= gnt_1 & ~we_1;
         if (r_rvalid_0) r_rdata_0 <= mem_out;
         if (r_rvalid_1) r_rdata_1 <= mem_out;
      end
   end

   assign rvalid_0 = r_rvalid_0;
   assign rvalid_1 = r_rvalid_1;
   assign rdata_0  = r_rvalid_0 ? mem_out : r_rdata_0;
   assign rdata_1  = r_rvalid_1 ? mem_out : r_rdata_1;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios, a grant table and
// randomized traffic checked against a transaction-level arbiter model.
module tb_mem_arb;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_0, lock_0, we_0, req_1, lock_1, we_1;
   logic [11:0] addr_0, addr_1, mem_addr;
   logic [31:0] wdata_0, wdata_1, rdata_0, rdata_1, mem_in, mem_out;
   logic        gnt_0, gnt_1, rvalid_0, rvalid_1, mem_we;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_arb #(.WIDTH(32), .AW(12), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
      .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
      .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out)
   );

   // Background content of never-written words.
   function automatic logic [31:0] init_val(input logic [11:0] a);
      if (a == 12'd5) return 32'hDEADBEEF;
      return {a, 8'h5A, ~a};
   endfunction

   // Synchronous-read single-port memory (read-first).
   logic [31:0] mem [4096];
   bit          written [4096];
   always @(posedge clk) begin
      mem_out <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
      if (mem_we) begin
         mem[mem_addr]     <= mem_in;
         written[mem_addr] <= 1'b1;
      end
   end

   // Reference model state.
   int          m_owner, m_run, m_last;
   bit          m_pend [2];
   logic [31:0] m_pdata [2];
   logic [31:0] m_hold [2];
   logic [11:0] m_addr;
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] ref_rd(input logic [11:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_run   = 0;
      m_last  = 1;
      m_addr  = '0;
      for (int k = 0; k < 2; k++) begin
         m_pend[k]  = 1'b0;
         m_hold[k]  = '0;
         m_pdata[k] = '0;
      end
   endtask

   // Compare this cycle's outputs with the model, then advance the model.
   task automatic model_cycle();
      bit          rq [2];
      bit          lk [2];
      bit          wr [2];
      logic [11:0] ad [2];
      logic [31:0] wd [2];
      int          g;
      logic [1:0]  eg;
      rq = '{req_0, req_1};  lk = '{lock_0, lock_1};  wr = '{we_0, we_1};
      ad = '{addr_0, addr_1}; wd = '{wdata_0, wdata_1};
      g = -1;
      if (m_owner >= 0 && lk[m_owner]) begin
         if (m_run >= MAXB && rq[1 - m_owner]) g = 1 - m_owner;
         else if (rq[m_owner])                 g = m_owner;
      end else if (rq[0] && rq[1]) begin
         g = (RR && m_last == 0) ? 1 : 0;
      end else if (rq[0]) begin
         g = 0;
      end else if (rq[1]) begin
         g = 1;
      end
      eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      check("gnt", {30'd0, gnt_1, gnt_0}, {30'd0, eg});
      check("mem_we", {31'd0, mem_we}, {31'd0, (g >= 0) && wr[g]});
      check("mem_addr", {20'd0, mem_addr}, {20'd0, (g >= 0) ? ad[g] : m_addr});
      if (g >= 0 && wr[g]) check("mem_in", mem_in, wd[g]);
      check("rvalid", {30'd0, rvalid_1, rvalid_0}, {30'd0, m_pend[1], m_pend[0]});
      check("rdata_0", rdata_0, m_pend[0] ? m_pdata[0] : m_hold[0]);
      check("rdata_1", rdata_1, m_pend[1] ? m_pdata[1] : m_hold[1]);
      for (int k = 0; k < 2; k++) begin
         if (m_pend[k]) m_hold[k] = m_pdata[k];
         m_pend[k] = 1'b0;
      end
      if (g >= 0) begin
         m_addr = ad[g];
         if (wr[g]) ref_mem[int'(ad[g])] = wd[g];
         else begin
            m_pend[g]  = 1'b1;
            m_pdata[g] = ref_rd(ad[g]);
         end
         if (m_owner == g && lk[g]) m_run++;
         else begin
            m_owner = lk[g] ? g : -1;
            m_run   = lk[g] ? 1 : 0;
         end
         m_last = g;
      end else if (m_owner >= 0 && !lk[m_owner]) begin
         m_owner = -1;
         m_run   = 0;
      end
   endtask

   task automatic finish_cycle();
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      #4;
      finish_cycle();
   endtask

   task automatic drive(input logic r0, input logic l0, input logic w0, input logic [11:0] a0,
                        input logic [31:0] d0, input logic r1, input logic l1, input logic w1,
                        input logic [11:0] a1, input logic [31:0] d1);
      req_0 = r0; lock_0 = l0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
      req_1 = r1; lock_1 = l1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"},    {30'd0, gnt_1, gnt_0}, 32'd0);
      check({tag, "_rvalid"}, {30'd0, rvalid_1, rvalid_0}, 32'd0);
      check({tag, "_rdata0"}, rdata_0, 32'd0);
      check({tag, "_rdata1"}, rdata_1, 32'd0);
      check({tag, "_we"},     {31'd0, mem_we}, 32'd0);
      check({tag, "_addr"},   {20'd0, mem_addr}, 32'd0);
      check({tag, "_min"},    mem_in, 32'd0);
   endtask

   // Entered and left one time unit after a rising edge.
   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   typedef struct {
      logic       r0, l0, r1, l1;
      logic [1:0] g_rr, g_fx;
   } vec_t;

   function automatic vec_t mk(input logic r0, input logic l0, input logic r1, input logic l1,
                               input logic [1:0] g_rr, input logic [1:0] g_fx);
      vec_t v;
      v.r0 = r0; v.l0 = l0; v.r1 = r1; v.l1 = l1; v.g_rr = g_rr; v.g_fx = g_fx;
      return v;
   endfunction

   initial begin
      vec_t        tbl [$];
      int          we_cnt;
      logic [11:0] apool [4];
      apool[0] = 12'h000; apool[1] = 12'h005; apool[2] = 12'h020; apool[3] = 12'hFFF;

      // ties, idle, burst cap, lock-hold starvation, ties again
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 0, 1, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 1, 2'b10, 2'b10));
      tbl.push_back(mk(1, 0, 1, 1, 2'b10, 2'b10));
      tbl.push_back(mk(1, 0, 1, 1, 2'b01, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 1, 0, 0, 2'b01, 2'b01));
      tbl.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 1, 1, 0, 2'b01, 2'b01));
      tbl.push_back(mk(0, 0, 1, 0, 2'b10, 2'b10));
      tbl.push_back(mk(1, 0, 1, 0, 2'b01, 2'b01));
      tbl.push_back(mk(1, 0, 1, 0, 2'b10, 2'b01));

      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      do_reset();

      // single read of preloaded word
      drive(1, 0, 0, 12'd5, 0, 0, 0, 0, 0, 0);
      #4;
      check("rd_gnt0", {31'd0, gnt_0}, 32'd1);
      finish_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      check("rd_rvalid0", {31'd0, rvalid_0}, 32'd1);
      check("rd_data0", rdata_0, 32'hDEADBEEF);
      finish_cycle();
      #4;
      check("rd_hold0", rdata_0, 32'hDEADBEEF);
      finish_cycle();

      // host write then read back of the top word
      we_cnt = 0;
      drive(0, 0, 0, 0, 0, 1, 0, 1, 12'hFFF, 32'h12345678);
      #4;
      we_cnt += int'(mem_we);
      finish_cycle();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 12'hFFF, 0);
      #4;
      we_cnt += int'(mem_we);
      finish_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      we_cnt += int'(mem_we);
      check("wr_rd_rvalid1", {31'd0, rvalid_1}, 32'd1);
      check("wr_rd_data1", rdata_1, 32'h12345678);
      check("wr_we_once", we_cnt, 32'd1);
      finish_cycle();

      // grant table from a fresh reset
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r0, tbl[i].l0, 0, 12'(10 + i), $urandom,
               tbl[i].r1, tbl[i].l1, 0, 12'(200 + i), $urandom);
         #4;
         check($sformatf("tbl%0d_gnt", i), {30'd0, gnt_1, gnt_0},
               {30'd0, RR ? tbl[i].g_rr : tbl[i].g_fx});
         finish_cycle();
      end

      // reset asserted in the middle of a granted read
      drive(1, 0, 0, 12'd5, 0, 0, 0, 0, 0, 0);
      #2;
      check("mr_gnt_pre", {31'd0, gnt_0}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check_reset_outputs("mr");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1, 0, 0, 12'h020, 0, 1, 0, 0, 12'h021, 0);
      #4;
      check("mr_rvalid_post", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      check("mr_tie_post", {30'd0, gnt_1, gnt_0}, 32'd1);
      finish_cycle();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 4,
               ($urandom_range(0, 3) == 0) ? 12'($urandom) : apool[$urandom_range(0, 3)], $urandom,
               $urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 4,
               ($urandom_range(0, 3) == 0) ? 12'($urandom) : apool[$urandom_range(0, 3)], $urandom);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter AW, default 12, word-address width (4096 words).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum consecutive grants to one port while the other port requests.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have, per requester k in {0 = core, 1 = host loader}: req_k in 1, valid request; lock_k in 1, hold ownership; we_k in 1, write; addr_k in AW; wdata_k in WIDTH; gnt_k out 1, request accepted this cycle; rvalid_k out 1, read data valid; rdata_k out WIDTH.
REQ-007 SHALL have memory side: mem_addr out AW, mem_in out WIDTH, mem_we out 1, mem_out in WIDTH; mem_out is valid one cycle after mem_addr is presented (synchronous-read single-port memory).

Function
REQ-008 SHALL accept at most one access per cycle; gnt_k is combinational from req_k and registered state; a transfer occurs when req_k && gnt_k.
REQ-009 SHALL drive mem_addr/mem_in from the granted port and mem_we = we_k && gnt_k; with no grant, mem_we SHALL be 0 and mem_addr SHALL hold its previous value.
REQ-010 SHALL assert rvalid_k exactly one cycle after an accepted read by port k, with rdata_k = mem_out; writes produce no rvalid.
REQ-011 SHALL hold rdata_k unchanged when rvalid_k is 0.
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-013 IDLE: only one req -> grant it, go to OWNk if lock_k else stay IDLE; both req -> apply priority policy (REQ-020/021).
REQ-014 OWNk: grant port k whenever req_k, never the other port; leave to IDLE when lock_k deasserts (same-cycle request still arbitrated from IDLE rules).
REQ-015 SHALL count consecutive grants to the owner in a burst counter; counter clears on ownership change or entry to IDLE.
REQ-016 When counter reaches MAX_BURST and the other port requests, SHALL force transition to OWN(other) (or IDLE if other's lock is low) regardless of lock, granting the other port that cycle.
REQ-017 Owner with lock high but req low SHALL keep ownership; other port is not granted (starvation bounded only by REQ-016 counting granted cycles; bench must not rely on idle-lock fairness).
REQ-018 Simultaneous req_0 and req_1 to the same address, one read one write: only the granted access occurs; the other waits, no merging.
REQ-019 Read-after-write to same address from the same port on consecutive cycles SHALL return the newly written data (memory write-first not assumed; arbiter imposes no extra bypass, relies on ordering of separate cycles).

Configuration
REQ-020 With MEM_ARB_RR_EN defined: IDLE tie SHALL go to the port not granted most recently (last-grant register, reset value port 1, so port 0 wins first tie).
REQ-021 Without MEM_ARB_RR_EN: IDLE tie SHALL always go to port 0; last-grant register absent.

Reset
REQ-022 On rst low, asynchronously: state IDLE, burst counter 0, gnt_k 0, rvalid_k 0, rdata_k 0, mem_we 0, mem_addr 0, mem_in 0, last-grant = 1.
REQ-023 A read accepted in the cycle reset asserts SHALL NOT produce rvalid after reset release.
REQ-024 First grant possible in the first rising edge cycle after rst deasserts.

Structure
REQ-025 SHALL place FSM state encodings (IDLE=0, OWN0=1, OWN1=2) and port IDs (PORT_CORE=0, PORT_HOST=1) in shared package mem_arb_pkg.
REQ-026 SHALL factor the two-way tie-break (fixed / round-robin, last-grant register) into sub-module arb2_pick; datapath mux and FSM stay in mem_arb.

Verification
REQ-027 Single read: port 0 req, addr 5, mem holds 0xDEADBEEF -> gnt_0 same cycle, rvalid_0 next cycle, rdata_0 = 0xDEADBEEF.
REQ-028 Tie: both req in IDLE, no lock, RR enabled -> grants alternate 0,1,0,1; RR disabled -> port 0 every cycle, gnt_1 never.
REQ-029 Burst cap: port 1 lock + req continuously, port 0 req from cycle 3, MAX_BURST=4 -> port 1 gets 4 consecutive grants, then gnt_0 next cycle.
REQ-030 Write then read: port 1 writes 0x12345678 to addr 0x0FFF, then reads 0x0FFF -> rdata_1 = 0x12345678, mem_we high exactly one cycle.
REQ-031 Reset mid-read: rst low in cycle a read is granted -> all outputs 0 immediately, no rvalid after release, first post-reset tie grants port 0.
